// File: rtl/lc4_seq_divider.sv
// Multi-cycle unsigned restoring divider for the LC4 DIV/MOD path, valid/ready on both sides.
// Optional early-out for zero divisor or dividend < divisor: define LC4_DIV_EARLY_OUT_EN.
module lc4_seq_divider #(
   parameter int WIDTH          = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_busy
);

   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);

   generate
      if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
          ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
         $error("lc4_seq_divider: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic [CNT_W-1:0] count;
   logic             dz;
`ifdef LC4_DIV_EARLY_OUT_EN
   logic             lt;
`endif

   logic [WIDTH-1:0] dvd_nxt;
   logic [WIDTH-1:0] rem_nxt;

   // One restoring step; the shifted-out MSB makes the compare WIDTH+1 bits wide,
   // and when it wins the true difference is below the divisor so WIDTH bits hold it exactly.
   function automatic logic [2*WIDTH-1:0] restore_step(input logic [WIDTH-1:0] rem,
                                                        input logic [WIDTH-1:0] dvd,
                                                        input logic [WIDTH-1:0] dvs);
      logic             top;
      logic [WIDTH-1:0] low;
      logic             ge;
      logic [WIDTH-1:0] rem_new;
      top     = rem[WIDTH-1];
      low     = {rem[WIDTH-2:0], dvd[WIDTH-1]};
      ge      = top || (low >= dvs);
      rem_new = ge ? (low - dvs) : low;
      return {rem_new, dvd[WIDTH-2:0], ge};
   endfunction

   always_comb begin
      dvd_nxt = dvd_q;
      rem_nxt = rem_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         {rem_nxt, dvd_nxt} = restore_step(rem_nxt, dvd_nxt, dvs_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         count       <= '0;
         dz          <= 1'b0;
`ifdef LC4_DIV_EARLY_OUT_EN
         lt          <= 1'b0;
`endif
         o_ready     <= 1'b1;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  dvd_q   <= i_dividend;
                  dvs_q   <= i_divisor;
                  rem_q   <= '0;
                  dz      <= (i_divisor == '0);
                  count   <= CNT_W'(STEPS);
                  state   <= CALC;
                  o_ready <= 1'b0;
                  o_busy  <= 1'b1;
`ifdef LC4_DIV_EARLY_OUT_EN
                  // Trivial cases spend a single CALC edge so o_valid follows accept by one edge.
                  lt      <= (i_dividend < i_divisor);
                  if ((i_divisor == '0) || (i_dividend < i_divisor))
                     count <= CNT_W'(1);
`endif
               end
            end
            CALC: begin
               dvd_q <= dvd_nxt;
               rem_q <= rem_nxt;
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state   <= DONE;
                  o_valid <= 1'b1;
                  if (dz) begin
                     o_quotient  <= '0;
                     o_remainder <= '0;
                  end
`ifdef LC4_DIV_EARLY_OUT_EN
                  else if (lt) begin
                     o_quotient  <= '0;
                     o_remainder <= dvd_q;
                  end
`endif
                  else begin
                     o_quotient  <= dvd_nxt;
                     o_remainder <= rem_nxt;
                  end
               end
            end
            DONE: begin
               if (i_ready) begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc4_seq_divider.sv
// Bench for lc4_seq_divider: vector table, back-pressure / reset sequences, and random ops
// on a 1-bit/cycle and a 4-bit/cycle instance against an arithmetic reference model.
module tb_lc4_seq_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv, ir, ov, ordy, busy;
   logic [15:0] a, b, q, r;
   logic        iv4, ir4, ov4, ordy4, busy4;
   logic [15:0] a4, b4, q4, r4;

   int n_chk  = 0;
   int n_pass = 0;

   lc4_seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_valid(iv), .o_ready(ordy), .i_dividend(a), .i_divisor(b),
      .o_valid(ov), .i_ready(ir), .o_quotient(q), .o_remainder(r), .o_busy(busy));

   lc4_seq_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .i_valid(iv4), .o_ready(ordy4), .i_dividend(a4), .i_divisor(b4),
      .o_valid(ov4), .i_ready(ir4), .o_quotient(q4), .o_remainder(r4), .o_busy(busy4));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] mq, output logic [15:0] mr);
      if (y == 16'd0) begin
         mq = 16'd0;
         mr = 16'd0;
      end else begin
         mq = x / y;
         mr = x % y;
      end
   endfunction

   function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y, input int bpc);
`ifdef LC4_DIV_EARLY_OUT_EN
      if ((y == 16'd0) || (x < y)) return 1;
`endif
      return 16 / bpc;
   endfunction

   // Issue one request and wait (bounded) for o_valid; leaves the DUT in its response phase.
   task automatic do_op(input bit s4, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] rq, output logic [15:0] rr, output int lat);
      chk("ready_before_accept", s4 ? ordy4 : ordy, 1'b1);
      if (s4) begin a4 = x; b4 = y; iv4 = 1'b1; end
      else    begin a  = x; b  = y; iv  = 1'b1; end
      @(posedge clk); #1;
      if (s4) iv4 = 1'b0; else iv = 1'b0;
      lat = 0;
      while (!(s4 ? ov4 : ov) && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 64) chk("valid_timeout", 32'd0, 32'd1);
      rq = s4 ? q4 : q;
      rr = s4 ? r4 : r;
   endtask

   task automatic handshake(input bit s4);
      if (s4) ir4 = 1'b1; else ir = 1'b1;
      @(posedge clk); #1;
      if (s4) ir4 = 1'b0; else ir = 1'b0;
      chk("valid_low_after_handshake", s4 ? ov4 : ov, 1'b0);
   endtask

   vec_t        vecs[10];
   logic [15:0] gq, gr, mq, mr, x, y;
   int          lat;
   bit          s4;

   initial begin
      vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2};
      vecs[1] = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000};
      vecs[2] = '{16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000};
      vecs[3] = '{16'd5,     16'd0,     16'd0,     16'd0};
      vecs[4] = '{16'd3,     16'd10,    16'd0,     16'd3};
      vecs[5] = '{16'd81,    16'd9,     16'd9,     16'd0};
      vecs[6] = '{16'd0,     16'd5,     16'd0,     16'd0};
      vecs[7] = '{16'd1,     16'd1,     16'd1,     16'd0};
      vecs[8] = '{16'h8000,  16'h8001,  16'h0000,  16'h8000};
      vecs[9] = '{16'hFFFE,  16'h00FF,  16'd256,   16'd254};

      rst_n = 1'b0;
      iv = 1'b0; ir = 1'b0; a = '0; b = '0;
      iv4 = 1'b0; ir4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ordy, 1'b1);
      chk("rst_valid", ov, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_quot", q, 16'd0);
      chk("rst_rem", r, 16'd0);
      chk("rst_ready4", ordy4, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         do_op(1'b0, vecs[i].a, vecs[i].b, gq, gr, lat);
         chk($sformatf("vec%0d_quot", i), gq, vecs[i].q);
         chk($sformatf("vec%0d_rem", i), gr, vecs[i].r);
         chk($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].a, vecs[i].b, 1));
         chk($sformatf("vec%0d_busy", i), busy, 1'b1);
         handshake(1'b0);
      end

      // Back-pressure: response held while consumer stalls, stray requests ignored.
      do_op(1'b0, 16'd1000, 16'd33, gq, gr, lat);
      chk("bp_lat", lat, exp_lat(16'd1000, 16'd33, 1));
      a = 16'd5; b = 16'd1; iv = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_valid_held", ov, 1'b1);
         chk("bp_ready_low", ordy, 1'b0);
         chk("bp_quot_held", q, 16'd30);
         chk("bp_rem_held", r, 16'd10);
      end
      ir = 1'b1;
      @(posedge clk); #1;
      ir = 1'b0; iv = 1'b0;
      chk("bp_valid_drop", ov, 1'b0);
      chk("bp_ready_back", ordy, 1'b1);
      chk("bp_idle_busy", busy, 1'b0);
      chk("bp_quot_after", q, 16'd30);
      chk("bp_rem_after", r, 16'd10);
      @(posedge clk); #1;
      chk("bp_no_stray_accept", busy, 1'b0);

      // Asynchronous reset in the middle of a calculation.
      a = 16'd1234; b = 16'd5; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", ov, 1'b0);
      chk("mid_rst_ready", ordy, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_quot", q, 16'd0);
      chk("mid_rst_rem", r, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(1'b0, 16'd81, 16'd9, gq, gr, lat);
      chk("post_rst_quot", gq, 16'd9);
      chk("post_rst_rem", gr, 16'd0);
      chk("post_rst_lat", lat, exp_lat(16'd81, 16'd9, 1));
      handshake(1'b0);

      // Four quotient bits per clock.
      do_op(1'b1, 16'd12345, 16'd123, gq, gr, lat);
      chk("bpc4_quot", gq, 16'd100);
      chk("bpc4_rem", gr, 16'd45);
      chk("bpc4_lat", lat, exp_lat(16'd12345, 16'd123, 4));
      handshake(1'b1);

      for (int n = 0; n < 60; n++) begin
         s4 = ($urandom_range(0, 1) == 1);
         x  = 16'($urandom);
         case ($urandom_range(0, 4))
            0:       y = 16'd0;
            1:       y = 16'($urandom_range(1, 15));
            2:       y = x + 16'($urandom_range(1, 7));
            default: y = 16'($urandom);
         endcase
         model(x, y, mq, mr);
         do_op(s4, x, y, gq, gr, lat);
         chk($sformatf("rnd%0d_quot", n), gq, mq);
         chk($sformatf("rnd%0d_rem", n), gr, mr);
         chk($sformatf("rnd%0d_lat", n), lat, exp_lat(x, y, s4 ? 4 : 1));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_hold", n), s4 ? q4 : q, mq);
         end
         handshake(s4);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
